// File: rtl/elevator_call_scheduler.sv
// Button latch and SCAN target selector for the elevator car controller.
// Hands one target floor at a time to the car FSM over a valid/arrived handshake.
module elevator_call_scheduler #(
  parameter int NFLOORS = 8,
  parameter int FW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] car_call,
  input  logic [NFLOORS-1:0] hall_up,
  input  logic [NFLOORS-1:0] hall_dn,
  input  logic [FW-1:0]      cur_floor,
  input  logic               arrived,
  output logic               tgt_valid,
  output logic [FW-1:0]      tgt_floor,
  output logic               dir_up,
  output logic               retarget,
  output logic [NFLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, PICK, DISPATCH, CLEAR} state_t;

  // Top floor has no up button, ground floor has no down button.
  localparam logic [NFLOORS-1:0] UP_OK = {1'b0, {(NFLOORS-1){1'b1}}};
  localparam logic [NFLOORS-1:0] DN_OK = {{(NFLOORS-1){1'b1}}, 1'b0};

  state_t             state, state_n;
  logic [NFLOORS-1:0] pc, pu, pd;
  logic [FW-1:0]      c;
  logic [NFLOORS-1:0] above, below, win_up, win_dn;
  logic [NFLOORS-1:0] a_up, b_up, a_dn, b_dn;
  logic               here;
  logic [FW-1:0]      sel_floor, rt_floor;
  logic               sel_dir, rt_hit;
  logic [NFLOORS-1:0] rt_set, tgt_onehot, clr_c, clr_u, clr_d;
  logic               do_pick, do_retarget, do_clear;

  function automatic logic [FW-1:0] lowest(input logic [NFLOORS-1:0] v);
    lowest = '0;
    for (int i = NFLOORS - 1; i >= 0; i--)
      if (v[i]) lowest = FW'(i);
  endfunction

  function automatic logic [FW-1:0] highest(input logic [NFLOORS-1:0] v);
    highest = '0;
    for (int i = 0; i < NFLOORS; i++)
      if (v[i]) highest = FW'(i);
  endfunction

  assign c       = (int'(cur_floor) >= NFLOORS) ? FW'(NFLOORS - 1) : cur_floor;
  assign pending = pc | pu | pd;
  assign here    = pending[c];

  // Position masks; the retarget windows exclude floors within one of the car.
  always_comb begin
    above  = '0;
    below  = '0;
    win_up = '0;
    win_dn = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      above[i]  = i > int'(c);
      below[i]  = i < int'(c);
      win_up[i] = (i >= int'(c) + 2) && (i < int'(tgt_floor));
      win_dn[i] = (i + 2 <= int'(c)) && (i > int'(tgt_floor));
    end
  end

  assign a_up = (pc | pu) & above;
  assign b_up = pd & above;
  assign a_dn = (pc | pd) & below;
  assign b_dn = pu & below;

  // With only the opposite hall call left at this floor, turn around so it gets served.
  always_comb begin
    sel_floor = tgt_floor;
    sel_dir   = dir_up;
    if (dir_up) begin
      if (|a_up)      begin sel_floor = lowest(a_up);  sel_dir = 1'b1; end
      else if (|b_up) begin sel_floor = highest(b_up); sel_dir = 1'b1; end
      else if (|a_dn) begin sel_floor = highest(a_dn); sel_dir = 1'b0; end
      else if (|b_dn) begin sel_floor = lowest(b_dn);  sel_dir = 1'b0; end
      else if (here)  begin sel_floor = c; sel_dir = !(pd[c] && !pc[c] && !pu[c]); end
    end else begin
      if (|a_dn)      begin sel_floor = highest(a_dn); sel_dir = 1'b0; end
      else if (|b_dn) begin sel_floor = lowest(b_dn);  sel_dir = 1'b0; end
      else if (|a_up) begin sel_floor = lowest(a_up);  sel_dir = 1'b1; end
      else if (|b_up) begin sel_floor = highest(b_up); sel_dir = 1'b1; end
      else if (here)  begin sel_floor = c; sel_dir = pu[c] && !pc[c] && !pd[c]; end
    end
  end

  always_comb begin
    rt_set   = dir_up ? (a_up & win_up) : (a_dn & win_dn);
    rt_hit   = |rt_set;
    rt_floor = dir_up ? lowest(rt_set) : highest(rt_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (|pending) state_n = PICK;
      PICK:     state_n = (|pending) ? DISPATCH : IDLE;
      DISPATCH: if (arrived) state_n = CLEAR;
      CLEAR:    state_n = PICK;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    tgt_valid   = 1'b0;
    do_pick     = 1'b0;
    do_retarget = 1'b0;
    do_clear    = 1'b0;
    unique case (state)
      PICK:     do_pick = |pending;
      DISPATCH: begin
        tgt_valid   = 1'b1;
        do_retarget = !arrived && rt_hit;
      end
      CLEAR:    do_clear = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    tgt_onehot            = '0;
    tgt_onehot[tgt_floor] = 1'b1;
    clr_c = do_clear ? tgt_onehot : '0;
    clr_u = (do_clear && dir_up) ? tgt_onehot : '0;
    clr_d = (do_clear && !dir_up) ? tgt_onehot : '0;
  end

  // A button held during the clear cycle does not survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      pu <= '0;
      pd <= '0;
    end else begin
      pc <= (pc | car_call) & ~clr_c;
      pu <= (pu | (hall_up & UP_OK)) & ~clr_u;
      pd <= (pd | (hall_dn & DN_OK)) & ~clr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_floor <= '0;
      dir_up    <= 1'b1;
      retarget  <= 1'b0;
    end else begin
      retarget <= do_retarget;
      if (do_pick) begin
        tgt_floor <= sel_floor;
        dir_up    <= sel_dir;
      end else if (do_retarget) begin
        tgt_floor <= rt_floor;
      end
    end
  end

endmodule
